// File: rtl/saturn_pc_rstk.sv
// Saturn program counter, nibble-serial jump-target accumulator and return stack.
// Define SATURN_RSTK_ERROR_EN to enable the sticky overflow/underflow flag on o_rstk_error.
module saturn_pc_rstk #(
    parameter int          RSTK_DEPTH = 8,
    parameter logic [19:0] PC_RESET   = 20'h00000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_en,
    input  logic [3:0]  i_phases,
    input  logic [1:0]  i_phase,
    input  logic [31:0] i_cycle_ctr,
    input  logic        i_bus_busy,
    input  logic [3:0]  i_nibble,
    input  logic        i_acc_clr,
    input  logic        i_acc_load,
    input  logic [2:0]  i_pc_cmd,
    output logic [19:0] o_current_pc,
    output logic [19:0] o_target,
    output logic [19:0] o_rstk_top,
    output logic [3:0]  o_rstk_level,
    output logic        o_rstk_error
);

    localparam int         IDX_W   = (RSTK_DEPTH > 1) ? $clog2(RSTK_DEPTH) : 1;
    localparam logic [3:0] DEPTH_L = 4'(RSTK_DEPTH);

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_INC       = 3'd1,
        CMD_JMP_ABS   = 3'd2,
        CMD_JMP_REL   = 3'd3,
        CMD_GOSUB_REL = 3'd4,
        CMD_RTN       = 3'd5,
        CMD_PUSH_ACC  = 3'd6,
        CMD_POP       = 3'd7
    } pc_cmd_e;

    // Sign-extend the accumulator from the top bit of the last loaded nibble.
    function automatic logic [19:0] sext_f(input logic [19:0] acc, input logic [2:0] ptr);
        logic [19:0] res;
        case (ptr)
            3'd1:    res = {{16{acc[3]}},  acc[3:0]};
            3'd2:    res = {{12{acc[7]}},  acc[7:0]};
            3'd3:    res = {{8{acc[11]}},  acc[11:0]};
            3'd4:    res = {{4{acc[15]}},  acc[15:0]};
            default: res = acc;
        endcase
        return res;
    endfunction

    logic [19:0] pc_r,  pc_nxt_s;
    logic [19:0] acc_r, acc_nxt_s;
    logic [2:0]  ptr_r, ptr_nxt_s;
    logic [19:0] stk_r     [RSTK_DEPTH];
    logic [19:0] stk_nxt_s [RSTK_DEPTH];
    logic [3:0]  lvl_r, lvl_nxt_s;
    logic [19:0] top_r, top_nxt_s;
    logic        upd_s;
    logic        push_s;
    logic        pop_s;
    logic [19:0] push_val_s;
    logic [19:0] rel_s;
    logic        stk_full_s;
    logic        stk_empty_s;
    logic        unused_s;

    assign upd_s       = i_clk_en & ~i_bus_busy;
    assign rel_s       = sext_f(acc_r, ptr_r);
    assign stk_full_s  = (lvl_r >= DEPTH_L);
    assign stk_empty_s = (lvl_r == 4'd0);
    assign unused_s    = ^{i_phase, i_cycle_ctr, i_phases[1:0]};

    // Accumulator loading (phase 2) and PC command decode (phase 3).
    always_comb begin
        acc_nxt_s  = acc_r;
        ptr_nxt_s  = ptr_r;
        pc_nxt_s   = pc_r;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        push_val_s = 20'h00000;
        if (upd_s && i_phases[2]) begin
            if (i_acc_clr) begin
                acc_nxt_s = 20'h00000;
                ptr_nxt_s = 3'd0;
            end else if (i_acc_load && (ptr_r < 3'd5)) begin
                case (ptr_r)
                    3'd0:    acc_nxt_s[3:0]   = i_nibble;
                    3'd1:    acc_nxt_s[7:4]   = i_nibble;
                    3'd2:    acc_nxt_s[11:8]  = i_nibble;
                    3'd3:    acc_nxt_s[15:12] = i_nibble;
                    3'd4:    acc_nxt_s[19:16] = i_nibble;
                    default: acc_nxt_s        = acc_r;
                endcase
                ptr_nxt_s = ptr_r + 3'd1;
            end else begin
                ptr_nxt_s = ptr_r;
            end
        end else begin
            acc_nxt_s = acc_r;
        end
        if (upd_s && i_phases[3]) begin
            case (pc_cmd_e'(i_pc_cmd))
                CMD_NOP:       pc_nxt_s = pc_r;
                CMD_INC:       pc_nxt_s = pc_r + 20'h00001;
                CMD_JMP_ABS:   pc_nxt_s = acc_r;
                CMD_JMP_REL:   pc_nxt_s = pc_r + rel_s;
                CMD_GOSUB_REL: begin
                    push_s     = 1'b1;
                    push_val_s = pc_r;
                    pc_nxt_s   = pc_r + rel_s;
                end
                CMD_RTN: begin
                    pop_s    = 1'b1;
                    pc_nxt_s = top_r;
                end
                CMD_PUSH_ACC: begin
                    push_s     = 1'b1;
                    push_val_s = acc_r;
                end
                CMD_POP:       pop_s    = 1'b1;
                default:       pc_nxt_s = pc_r;
            endcase
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Return stack next state; a push onto a full stack discards the oldest entry.
    always_comb begin
        stk_nxt_s = stk_r;
        lvl_nxt_s = lvl_r;
        top_nxt_s = top_r;
        if (push_s) begin
            if (stk_full_s) begin
                for (int i = 0; i < RSTK_DEPTH - 1; i++) begin
                    stk_nxt_s[i] = stk_r[i + 1];
                end
                stk_nxt_s[RSTK_DEPTH - 1] = push_val_s;
                lvl_nxt_s = lvl_r;
            end else begin
                stk_nxt_s[IDX_W'(lvl_r)] = push_val_s;
                lvl_nxt_s = lvl_r + 4'd1;
            end
        end else if (pop_s && !stk_empty_s) begin
            stk_nxt_s[IDX_W'(lvl_r - 4'd1)] = 20'h00000;
            lvl_nxt_s = lvl_r - 4'd1;
        end else begin
            lvl_nxt_s = lvl_r;
        end
        if (lvl_nxt_s == 4'd0) begin
            top_nxt_s = 20'h00000;
        end else begin
            top_nxt_s = stk_nxt_s[IDX_W'(lvl_nxt_s - 4'd1)];
        end
    end

    // State registers; next-state logic already holds when no update slot is open.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_r  <= PC_RESET;
            acc_r <= 20'h00000;
            ptr_r <= 3'd0;
            lvl_r <= 4'd0;
            top_r <= 20'h00000;
            for (int i = 0; i < RSTK_DEPTH; i++) begin
                stk_r[i] <= 20'h00000;
            end
        end else begin
            pc_r  <= pc_nxt_s;
            acc_r <= acc_nxt_s;
            ptr_r <= ptr_nxt_s;
            lvl_r <= lvl_nxt_s;
            top_r <= top_nxt_s;
            for (int i = 0; i < RSTK_DEPTH; i++) begin
                stk_r[i] <= stk_nxt_s[i];
            end
        end
    end

`ifdef SATURN_RSTK_ERROR_EN
    logic err_r;
    logic err_set_s;

    assign err_set_s = (push_s & stk_full_s) | (pop_s & stk_empty_s);

    // Sticky overflow/underflow flag, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | err_set_s;
        end
    end

    assign o_rstk_error = err_r;
`else
    assign o_rstk_error = 1'b0;
`endif

    assign o_current_pc = pc_r;
    assign o_target     = acc_r;
    assign o_rstk_top   = top_r;
    assign o_rstk_level = lvl_r;

endmodule

// File: tb/tb_saturn_pc_rstk.sv
// Directed bench for saturn_pc_rstk: queue-based reference model compared every cycle,
// plus hand-computed literal expectations.
module tb_saturn_pc_rstk;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_clk_en;
    logic [3:0]  i_phases;
    logic [1:0]  i_phase;
    logic [31:0] i_cycle_ctr;
    logic        i_bus_busy;
    logic [3:0]  i_nibble;
    logic        i_acc_clr;
    logic        i_acc_load;
    logic [2:0]  i_pc_cmd;
    logic [19:0] o_current_pc;
    logic [19:0] o_target;
    logic [19:0] o_rstk_top;
    logic [3:0]  o_rstk_level;
    logic        o_rstk_error;

    saturn_pc_rstk dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clk_en     (i_clk_en),
        .i_phases     (i_phases),
        .i_phase      (i_phase),
        .i_cycle_ctr  (i_cycle_ctr),
        .i_bus_busy   (i_bus_busy),
        .i_nibble     (i_nibble),
        .i_acc_clr    (i_acc_clr),
        .i_acc_load   (i_acc_load),
        .i_pc_cmd     (i_pc_cmd),
        .o_current_pc (o_current_pc),
        .o_target     (o_target),
        .o_rstk_top   (o_rstk_top),
        .o_rstk_level (o_rstk_level),
        .o_rstk_error (o_rstk_error)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: PC as a number, accumulator as a list of nibbles, stack as a queue.
    logic [19:0] m_pc;
    logic [3:0]  m_nibs[$];
    logic [19:0] m_stk[$];
    logic        m_err;

`ifdef SATURN_RSTK_ERROR_EN
    localparam logic ERR_EXPECTED = 1'b1;
`else
    localparam logic ERR_EXPECTED = 1'b0;
`endif

    function automatic logic [19:0] m_acc();
        logic [31:0] a = 32'd0;
        foreach (m_nibs[i]) a = a + (32'(m_nibs[i]) << (4 * i));
        return a[19:0];
    endfunction

    function automatic logic [19:0] m_rel();
        int n = m_nibs.size();
        logic [31:0] a = 32'(m_acc());
        if (n >= 1 && n <= 4 && a[4*n-1]) a = a - (32'd1 << (4 * n));
        return a[19:0];
    endfunction

    function automatic logic [19:0] m_top();
        return (m_stk.size() == 0) ? 20'h00000 : m_stk[m_stk.size()-1];
    endfunction

    task automatic m_push(input logic [19:0] v);
        if (m_stk.size() == 8) begin
            void'(m_stk.pop_front());
`ifdef SATURN_RSTK_ERROR_EN
            m_err = 1'b1;
`endif
        end
        m_stk.push_back(v);
    endtask

    task automatic m_pop(output logic [19:0] v);
        if (m_stk.size() == 0) begin
            v = 20'h00000;
`ifdef SATURN_RSTK_ERROR_EN
            m_err = 1'b1;
`endif
        end else begin
            v = m_stk.pop_back();
        end
    endtask

    task automatic m_reset();
        m_pc = 20'h00000;
        m_nibs.delete();
        m_stk.delete();
        m_err = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("pc",    32'(o_current_pc), 32'(m_pc));
            check("target", 32'(o_target),    32'(m_acc()));
            check("top",   32'(o_rstk_top),   32'(m_top()));
            check("level", 32'(o_rstk_level), 32'(m_stk.size()));
            check("error", 32'(o_rstk_error), 32'(m_err));
        end
    end

    task automatic idle();
        i_clk_en   = 1'b1;
        i_phases   = 4'b0000;
        i_bus_busy = 1'b0;
        i_nibble   = 4'h0;
        i_acc_clr  = 1'b0;
        i_acc_load = 1'b0;
        i_pc_cmd   = 3'd0;
    endtask

    task automatic step(input logic [3:0] ph, input logic [2:0] c, input logic [3:0] nib,
                        input logic clr, input logic ld, input logic en, input logic busy);
        logic [19:0] v;
        @(negedge i_clk);
        #1;
        i_phases = ph; i_pc_cmd = c; i_nibble = nib; i_acc_clr = clr; i_acc_load = ld;
        i_clk_en = en; i_bus_busy = busy;
        i_phase = (ph == 4'b1000) ? 2'd3 : 2'd2;
        @(posedge i_clk);
        #1;
        i_cycle_ctr = i_cycle_ctr + 32'd1;
        if (en && !busy) begin
            if (ph[2]) begin
                if (clr) m_nibs.delete();
                else if (ld && m_nibs.size() < 5) m_nibs.push_back(nib);
            end
            if (ph[3]) begin
                case (c)
                    3'd1: m_pc = m_pc + 20'h00001;
                    3'd2: m_pc = m_acc();
                    3'd3: m_pc = m_pc + m_rel();
                    3'd4: begin m_push(m_pc); m_pc = m_pc + m_rel(); end
                    3'd5: begin m_pop(v); m_pc = v; end
                    3'd6: m_push(m_acc());
                    3'd7: m_pop(v);
                    default: ;
                endcase
            end
        end
        idle();
    endtask

    task automatic cmd(input logic [2:0] c);
        step(4'b1000, c, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic ld(input logic [3:0] n);
        step(4'b0100, 3'd0, n, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic clr();
        step(4'b0100, 3'd0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        i_cycle_ctr = 32'd0;
        i_phase     = 2'd0;
        idle();
        i_reset = 1'b0;
        m_reset();
        repeat (3) @(posedge i_clk);
        #2 i_reset = 1'b1;
        chk_en = 1'b1;
        #1;
        check("rst_pc",    32'(o_current_pc), 32'h00000);
        check("rst_level", 32'(o_rstk_level), 32'h0);
        check("rst_top",   32'(o_rstk_top),   32'h00000);

        // Increment and hold conditions
        cmd(3'd1); cmd(3'd1); cmd(3'd1);
        check("inc3", 32'(o_current_pc), 32'h00003);
        step(4'b1000, 3'd1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("inc_busy", 32'(o_current_pc), 32'h00003);
        step(4'b1000, 3'd1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("inc_noen", 32'(o_current_pc), 32'h00003);

        // Absolute jump from a full five-nibble target
        clr(); ld(4'h4); ld(4'h3); ld(4'h2); ld(4'h1); ld(4'h0);
        check("target5", 32'(o_target), 32'h01234);
        cmd(3'd2);
        check("jmp_abs", 32'(o_current_pc), 32'h01234);
        ld(4'h9);
        check("load6_ignored", 32'(o_target), 32'h01234);

        // Relative jumps: negative offset and wrap past 2^20
        clr(); ld(4'h0); ld(4'h0); ld(4'h0); ld(4'h1); ld(4'h0); cmd(3'd2);
        clr(); ld(4'hE); ld(4'hF); cmd(3'd3);
        check("jmp_rel_neg", 32'(o_current_pc), 32'h00FFE);
        clr(); ld(4'h8); ld(4'hF); ld(4'hF); ld(4'hF); ld(4'hF); cmd(3'd2);
        check("pc_fff8", 32'(o_current_pc), 32'hFFFF8);
        clr(); ld(4'h0); ld(4'h1); cmd(3'd3);
        check("jmp_rel_wrap", 32'(o_current_pc), 32'h00008);

        // Subroutine call and return
        clr(); ld(4'h0); ld(4'h0); ld(4'h1); cmd(3'd2);
        clr(); ld(4'h0); ld(4'h4); ld(4'h0); cmd(3'd4);
        check("gosub_pc",    32'(o_current_pc), 32'h00140);
        check("gosub_top",   32'(o_rstk_top),   32'h00100);
        check("gosub_level", 32'(o_rstk_level), 32'h1);
        cmd(3'd5);
        check("rtn_pc",    32'(o_current_pc), 32'h00100);
        check("rtn_level", 32'(o_rstk_level), 32'h0);

        // Overflow by nine pushes, then drain and underflow
        for (int v = 1; v <= 9; v++) begin
            clr(); ld(4'(v)); cmd(3'd6);
        end
        check("full_level", 32'(o_rstk_level), 32'h8);
        check("full_top",   32'(o_rstk_top),   32'h00009);
        check("ovf_error",  32'(o_rstk_error), 32'(ERR_EXPECTED));
        for (int k = 0; k < 7; k++) cmd(3'd7);
        check("pop7_top",   32'(o_rstk_top),   32'h00002);
        check("pop7_level", 32'(o_rstk_level), 32'h1);
        cmd(3'd7);
        check("pop8_level", 32'(o_rstk_level), 32'h0);
        check("pop8_top",   32'(o_rstk_top),   32'h00000);
        cmd(3'd7);
        check("pop_empty_level", 32'(o_rstk_level), 32'h0);
        cmd(3'd5);
        check("rtn_empty_pc", 32'(o_current_pc), 32'h00000);
        check("udf_error",    32'(o_rstk_error), 32'(ERR_EXPECTED));

        // Asynchronous reset in the middle of an accumulator load
        clr(); ld(4'h5); ld(4'h6); cmd(3'd2); cmd(3'd6); ld(4'h7);
        check("pre_rst_pc", 32'(o_current_pc), 32'h00065);
        @(negedge i_clk);
        #1;
        i_phases = 4'b0100; i_acc_load = 1'b1; i_nibble = 4'hC;
        #1;
        i_reset = 1'b0;
        m_reset();
        #1;
        check("arst_pc",     32'(o_current_pc), 32'h00000);
        check("arst_target", 32'(o_target),     32'h00000);
        check("arst_top",    32'(o_rstk_top),   32'h00000);
        check("arst_level",  32'(o_rstk_level), 32'h0);
        check("arst_error",  32'(o_rstk_error), 32'h0);
        @(posedge i_clk);
        #2;
        idle();
        i_reset = 1'b1;
        ld(4'hA);
        check("post_rst_target", 32'(o_target), 32'h0000A);
        @(negedge i_clk);
        #1;
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
